// File: rtl/oled_pkg.sv
// Shared state encoding and SSD1306 command bytes for the OLED init sequencer.
package oled_pkg;

    typedef enum logic [2:0] {
        S_PWR,
        S_ISSUE,
        S_GAP,
        S_WAIT,
        S_READY
    } state_t;

    localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
    localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] CMD_ADDR_MODE   = 8'h20;
    localparam logic [7:0] CMD_NOP         = 8'hE3;

endpackage

// File: rtl/oled_cmd_rom.sv
// SSD1306 power-on command table; the last used entry always turns the panel on.
module oled_cmd_rom
    import oled_pkg::*;
#(
    parameter int unsigned NCMD = 26
) (
    input  logic [7:0] idx_i,
    output logic [7:0] byte_o
);

    localparam logic [7:0] LAST = (NCMD > 0) ? 8'(NCMD - 1) : 8'd0;

    always_comb begin
        byte_o = CMD_NOP;
        case (idx_i)
            8'd0:  byte_o = CMD_DISP_OFF;
            8'd1:  byte_o = 8'hD5;
            8'd2:  byte_o = 8'h80;
            8'd3:  byte_o = 8'hA8;
            8'd4:  byte_o = 8'h3F;
            8'd5:  byte_o = 8'hD3;
            8'd6:  byte_o = 8'h00;
            8'd7:  byte_o = 8'h40;
            8'd8:  byte_o = CMD_CHARGE_PUMP;
            8'd9:  byte_o = 8'h14;
            8'd10: byte_o = CMD_ADDR_MODE;
            8'd11: byte_o = 8'h00;
            8'd12: byte_o = 8'hA1;
            8'd13: byte_o = 8'hC8;
            8'd14: byte_o = 8'hDA;
            8'd15: byte_o = 8'h12;
            8'd16: byte_o = 8'h81;
            8'd17: byte_o = 8'hCF;
            8'd18: byte_o = 8'hD9;
            8'd19: byte_o = 8'hF1;
            8'd20: byte_o = 8'hDB;
            8'd21: byte_o = 8'h40;
            8'd22: byte_o = 8'hA4;
            8'd23: byte_o = 8'hA6;
            8'd24: byte_o = 8'h2E;
            default: byte_o = CMD_NOP;
        endcase
        if (NCMD > 0 && idx_i == LAST) begin
            byte_o = CMD_DISP_ON;
        end
    end

endmodule

// File: rtl/oled_i2c_sequencer.sv
// Waits for panel power-up, streams the init table to the i2c_master,
// then forwards single host bytes one transfer at a time.
module oled_i2c_sequencer
    import oled_pkg::*;
#(
    parameter int unsigned PWR_DELAY = 12_000_000,
    parameter int unsigned GAP       = 10,
    parameter int unsigned NCMD      = 26
) (
    input  logic       clk,
    input  logic       rst,
    output logic       i2c_start,
    output logic       i2c_dcn,
    output logic [7:0] i2c_data,
    input  logic       i2c_busy,
    input  logic       user_req,
    input  logic       user_dcn,
    input  logic [7:0] user_data,
    output logic       user_ack,
    output logic       init_done,
    output logic       seq_busy
);

    localparam logic [31:0] PWR_LOAD = 32'(PWR_DELAY);
    localparam logic [15:0] GAP_LOAD = 16'(GAP);
    localparam logic [7:0]  LAST     = (NCMD > 0) ? 8'(NCMD - 1) : 8'd0;

    state_t      state_q = S_PWR;
    logic [31:0] pwr_q   = PWR_LOAD;
    logic [15:0] gap_q   = '0;
    logic [7:0]  idx_q   = '0;
    logic        user_q  = 1'b0;
    logic        start_q = 1'b0;
    logic        dcn_q   = 1'b0;
    logic [7:0]  data_q  = '0;
    logic        ack_q   = 1'b0;
    logic        done_q  = 1'b0;
    logic        busy_q  = 1'b1;

    logic [7:0]  idx_d;
    logic [7:0]  rom_byte;

    // ROM looks ahead so the byte is registered together with the start pulse
    assign idx_d = (state_q == S_WAIT) ? idx_q + 8'd1 : idx_q;

    oled_cmd_rom #(.NCMD(NCMD)) u_rom (
        .idx_i (idx_d),
        .byte_o(rom_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PWR;
            pwr_q   <= PWR_LOAD;
            gap_q   <= '0;
            idx_q   <= '0;
            user_q  <= 1'b0;
            start_q <= 1'b0;
            dcn_q   <= 1'b0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            start_q <= 1'b0;
            ack_q   <= 1'b0;
            case (state_q)
                S_PWR: begin
                    if (pwr_q != '0) begin
                        pwr_q <= pwr_q - 32'd1;
                    end else if (NCMD == 0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_READY;
                    end else begin
                        idx_q   <= '0;
                        user_q  <= 1'b0;
                        start_q <= 1'b1;
                        dcn_q   <= 1'b0;
                        data_q  <= rom_byte;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    gap_q   <= GAP_LOAD;
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    if (gap_q <= 16'd1) begin
                        gap_q   <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        gap_q <= gap_q - 16'd1;
                    end
                end
                S_WAIT: begin
                    if (!i2c_busy) begin
                        if (user_q) begin
                            user_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= S_READY;
                        end else if (idx_q < LAST) begin
                            idx_q   <= idx_d;
                            start_q <= 1'b1;
                            dcn_q   <= 1'b0;
                            data_q  <= rom_byte;
                            state_q <= S_ISSUE;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_READY;
                        end
                    end
                end
                S_READY: begin
                    if (user_req) begin
                        data_q  <= user_data;
                        dcn_q   <= user_dcn;
                        start_q <= 1'b1;
                        ack_q   <= 1'b1;
                        user_q  <= 1'b1;
                        gap_q   <= GAP_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= S_GAP;
                    end
                end
                default: state_q <= S_PWR;
            endcase
        end
    end

    assign i2c_start = start_q;
    assign i2c_dcn   = dcn_q;
    assign i2c_data  = data_q;
    assign user_ack  = ack_q;
    assign init_done = done_q;
    assign seq_busy  = busy_q;

endmodule

// File: tb/tb_oled_i2c_sequencer.sv
// Scoreboard bench: init stream, busy stall, host writes, mid-init reset, empty table.
module tb_oled_i2c_sequencer;

    localparam int PWR  = 20;
    localparam int GAPC = 3;
    localparam int N    = 26;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start, dcn, ack, done, sbusy, busy;
    logic [7:0] data;
    logic       req = 1'b0, udcn = 1'b0;
    logic [7:0] udata = 8'h00;

    logic       rst0 = 1'b1;
    logic       start0, dcn0, ack0, done0, sbusy0;
    logic [7:0] data0;
    logic       busy0 = 1'b0;
    logic       req0 = 1'b0, udcn0 = 1'b0;
    logic [7:0] udata0 = 8'h00;

    oled_i2c_sequencer #(.PWR_DELAY(PWR), .GAP(GAPC), .NCMD(N)) dut (
        .clk(clk), .rst(rst), .i2c_start(start), .i2c_dcn(dcn),
        .i2c_data(data), .i2c_busy(busy), .user_req(req),
        .user_dcn(udcn), .user_data(udata), .user_ack(ack),
        .init_done(done), .seq_busy(sbusy)
    );

    oled_i2c_sequencer #(.PWR_DELAY(PWR), .GAP(GAPC), .NCMD(0)) dut0 (
        .clk(clk), .rst(rst0), .i2c_start(start0), .i2c_dcn(dcn0),
        .i2c_data(data0), .i2c_busy(busy0), .user_req(req0),
        .user_dcn(udcn0), .user_data(udata0), .user_ack(ack0),
        .init_done(done0), .seq_busy(sbusy0)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_rom(input int i);
        case (i)
            0: return 8'hAE;   1: return 8'hD5;   2: return 8'h80;
            3: return 8'hA8;   4: return 8'h3F;   5: return 8'hD3;
            6: return 8'h00;   7: return 8'h40;   8: return 8'h8D;
            9: return 8'h14;  10: return 8'h20;  11: return 8'h00;
            12: return 8'hA1; 13: return 8'hC8;  14: return 8'hDA;
            15: return 8'h12; 16: return 8'h81;  17: return 8'hCF;
            18: return 8'hD9; 19: return 8'hF1;  20: return 8'hDB;
            21: return 8'h40; 22: return 8'hA4;  23: return 8'hA6;
            24: return 8'h2E; 25: return 8'hAF;
            default: return 8'hE3;
        endcase
    endfunction

    logic [9:0] sb[$];
    int cyc = 0;
    int rel = 0, np = 0, nack = 0, last_s = 0, stall_n = 0;
    int np0 = 0, rel0 = 0;
    logic b1 = 1'b0, b2 = 1'b0, rst_e = 1'b0, done_prev = 1'b0;
    logic [8:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_e <= rst;

    // i2c_master model: busy from 2 cycles after start, for 40 (or 500) cycles
    int t = 0, hold = 40;
    always @(posedge clk) begin
        if (start) begin
            t <= 1;
            hold <= (stall_n != 0 && np == stall_n) ? 500 : 40;
        end else if (t != 0 && t < 1000) begin
            t <= t + 1;
        end
    end
    assign busy = (t >= 2 && t < hold + 2);

    always @(negedge clk) begin : mon
        logic [9:0] e;
        if (rst_e) held = '0;
        if (start) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                check("byte", {ack, dcn, data}, e);
                if (np == 0) begin
                    check("first_start_cyc", cyc - rel, PWR + 1);
                end else begin
                    check("spacing_ok", 32'((cyc - last_s) >= GAPC + 2), 1);
                    if (!e[9]) check("issue_after_busy_fall", {b2, b1}, 2'b10);
                    if (stall_n == 3 && np == 3) check("stall_release", cyc - last_s, 503);
                end
            end
            np++;
            last_s = cyc;
            held = {dcn, data};
        end else begin
            if ({dcn, data} !== held) check("data_hold", {dcn, data}, held);
            if (ack) check("ack_without_start", ack, 0);
        end
        if (ack) nack++;
        if (done && !done_prev) check("done_after_busy_fall", {b2, b1}, 2'b10);
        done_prev = done;
        b2 = b1;
        b1 = busy;
        if (start0) np0++;
    end

    task automatic check_reset_vals();
        check("rst_start", start, 0);
        check("rst_dcn", dcn, 0);
        check("rst_data", data, 8'h00);
        check("rst_ack", ack, 0);
        check("rst_done", done, 0);
        check("rst_seq_busy", sbusy, 1);
    endtask

    task automatic push_init();
        sb.delete();
        for (int i = 0; i < N; i++) sb.push_back({2'b00, exp_rom(i)});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals();

        // phase 1: full init with a stall on pulse 3 and a host request held throughout
        stall_n = 3;
        push_init();
        for (int i = 0; i < 3; i++) sb.push_back({2'b11, 8'h55});
        rst = 1'b0;
        rel = cyc;
        np = 0;
        req = 1'b1;
        udata = 8'h55;
        udcn = 1'b1;
        while (cyc < rel + PWR) @(negedge clk);
        check("no_early_start", np, 0);
        check("seq_busy_pwr", sbusy, 1);
        for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
        check("init_done", done, 1);
        check("init_pulses", np, N);
        for (int i = 0; i < 1000 && nack < 3; i++) @(negedge clk);
        req = 1'b0;
        repeat (100) @(negedge clk);
        check("user_acks", nack, 3);
        check("sb_empty", 32'(sb.size()), 0);
        check("total_pulses", np, N + 3);
        check("ready_idle", sbusy, 0);

        // phase 2: reset during pulse 10's transfer, then a complete rerun
        stall_n = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        np = 0;
        push_init();
        for (int i = 0; i < 2000 && np < 10; i++) @(negedge clk);
        check("reach_pulse10", np, 10);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        rel = cyc;
        np = 0;
        push_init();
        while (cyc < rel + PWR) @(negedge clk);
        check("restart_no_early", np, 0);
        check("restart_done_low", done, 0);
        for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
        check("restart_done", done, 1);
        check("restart_pulses", np, N);
        check("restart_sb_empty", 32'(sb.size()), 0);

        // phase 3: empty table goes straight to ready
        @(negedge clk);
        rst0 = 1'b0;
        rel0 = cyc;
        while (cyc < rel0 + PWR) @(negedge clk);
        check("ncmd0_done_c20", done0, 0);
        @(negedge clk);
        check("ncmd0_done_c21", done0, 1);
        check("ncmd0_no_pulses", np0, 0);
        check("ncmd0_idle", sbusy0, 0);
        req0 = 1'b1;
        udata0 = 8'hA5;
        udcn0 = 1'b1;
        @(negedge clk);
        check("ncmd0_ack", ack0, 1);
        check("ncmd0_start", start0, 1);
        check("ncmd0_byte", {dcn0, data0}, 9'h1A5);
        req0 = 1'b0;
        repeat (20) @(negedge clk);
        check("ncmd0_one_pulse", np0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
